// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide add/subtract sequenced through one shared
// 4-bit ripple adder, one nibble per cycle, LSB nibble first.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: start is a request that is taken on any rising edge where the
// controller is in IDLE or DONE. busy is high for exactly the NIBBLES RUN
// cycles. done is a one-cycle pulse in DONE, and result/carry_out are valid
// from that cycle until the next accepted start. start is ignored during RUN.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic                   ovf,
`endif
  output logic [1:0]             state_dbg
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;      // B already inverted for subtract
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             accept;
  logic             last;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last      = (idx == LAST_IDX);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and adder-side outputs; adder inputs are zero outside RUN.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = nib_a;
        add_b   = nib_b;
        add_cin = carry_reg;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the current nibble of each latched operand.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == k[IDX_W-1:0]) begin
        nib_a = a_reg[4*k +: 4];
        nib_b = b_reg[4*k +: 4];
      end
    end
  end

  // Operand latch, carry threading, result capture and final flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      a_reg     <= op_a;
      // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
      b_reg     <= sub ? ~op_b : op_b;
      carry_reg <= sub;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (state == RUN) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (idx == k[IDX_W-1:0]) result[4*k +: 4] <= add_sum;
      end
      carry_reg <= add_cout;
      idx       <= idx + IDX_W'(1);
      if (last) begin
        carry_out <= add_cout;
`ifdef SERIAL_ADD_OVF_EN
        // Signed overflow: operands agree in sign but the top sum bit does not.
        ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized and directed bench for the
// nibble-serial add/subtract controller with a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic [1:0]   state_dbg;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  // The shared external 4-bit ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the whole operands.
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, b, input bit s);
    longint r;
    r = s ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
    return W'(r);
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] a, b, input bit s);
    if (s) return (a >= b);
    return ((longint'(a) + longint'(b)) >= (64'sd1 <<< W));
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input bit s);
    longint sa, sb, r, lim;
    lim = 64'sd1 <<< (W - 1);
    sa = a[W-1] ? longint'(a) - 2 * lim : longint'(a);
    sb = b[W-1] ? longint'(b) - 2 * lim : longint'(b);
    r  = s ? sa - sb : sa + sb;
    return (r >= lim) || (r < -lim);
  endfunction

  // Carry entering nibble k: carry out of the low 4k bits of A + Beff + sub.
  function automatic logic ref_cin(input logic [W-1:0] a, b, input bit s, input int k);
    longint mask, beff;
    mask = (64'sd1 <<< (4 * k)) - 1;
    beff = s ? longint'(W'(~b)) : longint'(b);
    return 1'((((longint'(a) & mask) + (beff & mask) + longint'(s)) >>> (4 * k)) & 1);
  endfunction

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int k);
    return 4'(v >> (4 * k));
  endfunction

  // Driver: called just after a negedge. Launches one op, scrambles inputs
  // during RUN, checks each RUN cycle and the DONE cycle, and returns at the
  // DONE-cycle negedge with start low (caller may re-assert for back-to-back).
  task automatic run_op(input logic [W-1:0] a, b, input bit s, input string tag);
    logic [W-1:0] beff;
    beff  = s ? ~b : b;
    start = 1'b1; sub = s; op_a = a; op_b = b;
    @(posedge clk);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, W'(busy), W'(1));
      check({tag, "_add_a"}, W'(add_a), W'(nib(a, k)));
      check({tag, "_add_b"}, W'(add_b), W'(nib(beff, k)));
      check({tag, "_add_cin"}, W'(add_cin), W'(ref_cin(a, b, s, k)));
      // Changes and requests during RUN must be ignored.
      start = 1'($urandom_range(0, 1));
      sub   = 1'($urandom_range(0, 1));
      op_a  = W'($urandom);
      op_b  = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_busy_done"}, W'(busy), W'(0));
    check({tag, "_add_a_idle"}, W'({add_a, add_b, add_cin}), W'(0));
    check({tag, "_result"}, W'(result), W'(ref_result(a, b, s)));
    check({tag, "_carry"}, W'(carry_out), W'(ref_carry(a, b, s)));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, W'(ovf), W'(ref_ovf(a, b, s)));
`endif
  endtask

  // One idle cycle after DONE: flags drop, result holds.
  task automatic idle_check(input logic [W-1:0] exp_res, input logic exp_c, input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, W'(done), W'(0));
    check({tag, "_idle_busy"}, W'(busy), W'(0));
    check({tag, "_hold_result"}, W'(result), W'(exp_res));
    check({tag, "_hold_carry"}, W'(carry_out), W'(exp_c));
  endtask

  // Stimulus and final report.
  initial begin
    logic [W-1:0] ra, rb;
    bit rs;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    // Reset has priority over start.
    start = 1'b1;
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", W'(result), W'(0));
    check("rst_carry", W'(carry_out), W'(0));
    check("rst_adder", W'({add_a, add_b, add_cin}), W'(0));
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", W'(busy), W'(0));

    // Directed cases.
    run_op(16'h1234, 16'h4321, 1'b0, "add");
    idle_check(16'h5555, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, 1'b0, "wrap");
    idle_check(16'h0000, 1'b1, "wrap");
    run_op(16'h0005, 16'h0007, 1'b1, "borrow");
    idle_check(16'hFFFE, 1'b0, "borrow");
    run_op(16'h0007, 16'h0005, 1'b1, "noborrow");
    // Back-to-back: start asserted in the DONE cycle.
    run_op(16'h0001, 16'h0001, 1'b0, "b2b");
    idle_check(16'h0002, 1'b0, "b2b");
    run_op(16'h7FFF, 16'h0001, 1'b0, "ovf_add");
    run_op(16'h8000, 16'h0001, 1'b1, "ovf_sub");
    run_op(16'h1000, 16'h1000, 1'b0, "no_ovf");
    idle_check(16'h2000, 1'b0, "no_ovf");

    // Reset in RUN cycle 2 aborts with no done pulse.
    start = 1'b1; sub = 1'b0; op_a = 16'h1234; op_b = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), W'(0));
    check("abort_result", W'(result), W'(0));
    check("abort_carry", W'(carry_out), W'(0));
    rst_n = 1'b1;
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", W'(done), W'(0));
    end
    run_op(16'h1234, 16'h1111, 1'b0, "rerun");
    idle_check(16'h2345, 1'b0, "rerun");

    // Randomized operations, sometimes chained back-to-back.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(ra, rb, rs, "rand");
      if ($urandom_range(0, 1) == 1)
        idle_check(ref_result(ra, rb, rs), ref_carry(ra, rb, rs), "rand");
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that time-shares one external 4-bit ripple adder (a, b, carin -> sum, carout) to perform a wide add or subtract one nibble per cycle, LSB nibble first. It latches the operands on start and drives the adder inputs. It captures each sum nibble and threads the carry between cycles, then reports a registered result. It sits between the ALU opcode decode and the shared 4-bit adder instance.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when state is IDLE or DONE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
op_a  input  W  operand A; sampled with start
op_b  input  W  operand B; sampled with start
add_a  output  4  to adder a
add_b  output  4  to adder b
add_cin  output  1  to adder carin
add_sum  input  4  from adder sum (combinational return)
add_cout  input  1  from adder carout (combinational return)
busy  output  1  high while sequencing
done  output  1  one-cycle pulse, result valid
result  output  W  registered sum/difference
carry_out  output  1  final carry; for sub: 1 = no borrow (a >= b unsigned)

Behaviour:
- Reset: synchronous active-low; rst_n sampled low at a rising edge forces state IDLE, result=0, carry_out=0, busy=0, done=0, nibble index=0, operand regs=0. Reset mid-RUN aborts the operation with no done pulse. Reset has priority over start.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge T: latch op_a, sub, and op_b; op_b is stored inverted when sub=1. Carry reg = sub. result cleared to 0. Index = 0. Next state RUN.
- IDLE + start=0: stay in IDLE.
- DONE + start=0: go to IDLE.
- RUN cycle k (k = 0..NIBBLES-1): add_a = A[4k+3:4k], add_b = Beff[4k+3:4k], add_cin = carry reg. All three are combinational from the registers.
  - At the edge closing cycle k: result[4k+3:4k] <= add_sum; carry reg <= add_cout; index <= k+1.
  - On k = NIBBLES-1: carry_out <= add_cout and state <= DONE.
- Latency: start at edge T gives RUN for the NIBBLES cycles after T. DONE, with done=1, is the cycle after the last RUN cycle, i.e. done is high in cycle T+NIBBLES+1.
- busy = 1 exactly while in RUN; done = 1 exactly while in DONE.
- Back-to-back: start during DONE is accepted; the next RUN begins immediately with no idle cycle.
- start during RUN is ignored (no queueing); op_a, op_b, and sub changes during RUN have no effect.
- Outside RUN: add_a = 0, add_b = 0, add_cin = 0.
- result and carry_out hold their value from DONE until the next accepted start.
- Width rules:
  - result is W bits, modulo 2^W.
  - carry_out is the carry out of bit W-1.
  - Subtract is A + ~B + 1.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit).
  - ovf is registered at the same edge as carry_out.
  - ovf = (A[W-1] == Beff[W-1]) && (add_sum[3] != A[W-1]) in the last nibble, i.e. signed two's-complement overflow.
  - Reset value 0; cleared on accepted start; held like carry_out.
- Undefined: port ovf absent, no related logic.

Test Plan:
- Add, NIBBLES=4: op_a=0x1234, op_b=0x4321, sub=0, start one cycle -> busy high 4 cycles; add_a sequence 4,3,2,1; done in cycle T+5; result=0x5555, carry_out=0.
- Wrap: op_a=0xFFFF, op_b=0x0001, sub=0 -> add_cin sequence 0,1,1,1; result=0x0000, carry_out=1.
- Subtract with borrow: op_a=0x0005, op_b=0x0007, sub=1 -> first add_b=0x8, add_cin=1; result=0xFFFE, carry_out=0. Then op_a=0x0007, op_b=0x0005 -> result=0x0002, carry_out=1.
- Busy/back-to-back: assert start again during RUN with op_a=0xAAAA -> ignored, result from the first op. Then assert start in the DONE cycle with 0x0001+0x0001 -> RUN follows immediately; result=0x0002 after 4 more cycles.
- Reset mid-op: start 0x1234+0x1111, drive rst_n=0 in RUN cycle 2 -> next cycle busy=0, result=0, carry_out=0, no done pulse. Release rst_n and rerun -> result=0x2345.
- With SERIAL_ADD_OVF_EN: 0x7FFF+0x0001 -> result=0x8000, ovf=1, carry_out=0; 0x8000-0x0001 -> result=0x7FFF, ovf=1; 0x1000+0x1000 -> ovf=0.
